bcd_display_counter: RTL and testbench

//  - Parametrised N-digit BCD up/down counter driving a time-multiplexed common-anode 7-segment display.
//  - Successor to the single-digit BCD-to-segment decoder; adds a count prescaler, digit scanning and leading-zero blanking.
//  - Sits between board switches/buttons and the segment/anode pins.

---
 rtl/seg_pkg.sv | 19 +
 rtl/bcd_seg7_decode.sv | 29 ++
 rtl/bcd_display_counter.sv | 137 +++++++++++++
 tb/tb_bcd_display_counter.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared 7-segment constants (abcdefg, seg[6]=a, active-low) for display blocks.
package seg_pkg;

    typedef logic [3:0] bcd_digit_t;
    typedef logic [6:0] seg_pat_t;

    localparam seg_pat_t SEG_BLANK = 7'b1111111;
    localparam seg_pat_t SEG_0     = 7'b0000001;
    localparam seg_pat_t SEG_1     = 7'b1001111;
    localparam seg_pat_t SEG_2     = 7'b0010010;
    localparam seg_pat_t SEG_3     = 7'b0000110;
    localparam seg_pat_t SEG_4     = 7'b1001100;
    localparam seg_pat_t SEG_5     = 7'b0100100;
    localparam seg_pat_t SEG_6     = 7'b0100000;
    localparam seg_pat_t SEG_7     = 7'b0001111;
    localparam seg_pat_t SEG_8     = 7'b0000000;
    localparam seg_pat_t SEG_9     = 7'b0000100;

endpackage

// File: rtl/bcd_seg7_decode.sv
// Combinational BCD digit to active-low abcdefg pattern, with forced blanking.
module bcd_seg7_decode
    import seg_pkg::*;
(
    input  logic [3:0] digit_i,
    input  logic       blank_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = SEG_BLANK;
        if (!blank_i) begin
            case (digit_i)
                4'd0:    seg_o = SEG_0;
                4'd1:    seg_o = SEG_1;
                4'd2:    seg_o = SEG_2;
                4'd3:    seg_o = SEG_3;
                4'd4:    seg_o = SEG_4;
                4'd5:    seg_o = SEG_5;
                4'd6:    seg_o = SEG_6;
                4'd7:    seg_o = SEG_7;
                4'd8:    seg_o = SEG_8;
                4'd9:    seg_o = SEG_9;
                default: seg_o = SEG_BLANK;
            endcase
        end
    end

endmodule

// File: rtl/bcd_display_counter.sv
// N-digit BCD up/down counter with prescaler, scanned common-anode display
// and optional leading-zero blanking.
module bcd_display_counter
    import seg_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000000,
    parameter int SCAN_DIV = 100000,
    parameter int BLANK_LZ = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic                  up,
    input  logic                  clear,
    output logic [4*DIGITS-1:0]   count_bcd,
    output logic                  wrap,
    output logic [DIGITS-1:0]     an,
    output logic [6:0]            seg
);

    localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam logic [PRE_W-1:0]  PRE_LAST  = PRE_W'(TICK_DIV - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(DIGITS - 1);

    logic [PRE_W-1:0]       pre_q, pre_d;
    logic [SCAN_W-1:0]      scan_q, scan_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [DIGITS-1:0][3:0] count_q, count_d, count_step;
    logic                   wrap_q, wrap_d;
    logic [DIGITS-1:0]      an_q, an_d;
    logic [6:0]             seg_q, seg_d;

    logic                   tick;
    logic                   scan_step;
    logic [DIGITS-1:0]      is9, is0, sel, cin, blank_hit;
    logic [3:0]             digit_sel;
    logic                   blank;

    assign tick      = en && (pre_q == PRE_LAST);
    assign scan_step = (scan_q == SCAN_LAST);
    assign sel       = up ? is9 : is0;

    // Carry-in per digit comes from a reduction over the lower digits, so the
    // ripple has no combinational self-loop through a shared vector.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            assign is9[gi] = (count_q[gi] == 4'd9);
            assign is0[gi] = (count_q[gi] == 4'd0);

            if (gi == 0) begin : g_lsd
                assign cin[gi]       = tick;
                assign blank_hit[gi] = 1'b0;
            end else begin : g_upper
                assign cin[gi]       = tick && (&sel[gi-1:0]);
                assign blank_hit[gi] = (idx_q == IDX_W'(gi)) && (&is0[DIGITS-1:gi]);
            end

            assign count_step[gi] = !cin[gi] ? count_q[gi] :
                                    up       ? (is9[gi] ? 4'd0 : count_q[gi] + 4'd1) :
                                               (is0[gi] ? 4'd9 : count_q[gi] - 4'd1);

            assign an_d[gi] = (idx_q != IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        pre_d = pre_q;
        if (clear || tick) begin
            pre_d = '0;
        end else if (en) begin
            pre_d = pre_q + 1'b1;
        end
    end

    assign count_d = clear ? '0 : count_step;
    assign wrap_d  = !clear && tick && (&sel);

    always_comb begin
        scan_d = scan_step ? '0 : scan_q + 1'b1;
        idx_d  = idx_q;
        if (DIGITS == 1) begin
            idx_d = '0;
        end else if (scan_step) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end
    end

    always_comb begin
        digit_sel = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                digit_sel = count_q[i];
            end
        end
    end

    assign blank = (BLANK_LZ != 0) && (|blank_hit);

    bcd_seg7_decode u_decode (
        .digit_i (digit_sel),
        .blank_i (blank),
        .seg_o   (seg_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pre_q   <= '0;
            count_q <= '0;
            wrap_q  <= 1'b0;
            scan_q  <= '0;
            idx_q   <= '0;
            an_q    <= '1;
            seg_q   <= SEG_BLANK;
        end else begin
            pre_q   <= pre_d;
            count_q <= count_d;
            wrap_q  <= wrap_d;
            scan_q  <= scan_d;
            idx_q   <= idx_d;
            if (scan_step) begin
                an_q  <= an_d;
                seg_q <= seg_d;
            end
        end
    end

    assign count_bcd = count_q;
    assign wrap      = wrap_q;
    assign an        = an_q;
    assign seg       = seg_q;

endmodule

// File: tb/tb_bcd_display_counter.sv
// Scoreboard bench: stimulus queues expected count changes and scan steps,
// independent monitors pop and compare when the outputs move.
module tb_bcd_display_counter;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en, up, clear;
    logic [15:0] count_bcd, count_nb;
    logic        wrap, wrap_nb;
    logic [3:0]  an, an_nb;
    logic [6:0]  seg, seg_nb;

    int tests = 0;
    int fails = 0;
    int cyc   = 0;
    bit mon_en = 1'b1;

    typedef struct {
        logic [15:0] cnt;
        logic        wrp;
        int          cyc;
    } cnt_exp_t;

    typedef struct {
        logic [3:0] an;
        logic [6:0] seg;
        logic [6:0] seg_nb;
    } scan_exp_t;

    cnt_exp_t  cnt_q[$];
    scan_exp_t scan_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    bcd_display_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(1)) dut (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
        .count_bcd(count_bcd), .wrap(wrap), .an(an), .seg(seg)
    );

    bcd_display_counter #(.DIGITS(4), .TICK_DIV(4), .SCAN_DIV(2), .BLANK_LZ(0)) dut_nb (
        .clk(clk), .rst(rst), .en(en), .up(up), .clear(clear),
        .count_bcd(count_nb), .wrap(wrap_nb), .an(an_nb), .seg(seg_nb)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    function automatic logic [15:0] bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic push_cnt(input logic [15:0] v, input logic w, input int c);
        cnt_exp_t e;
        e.cnt = v;
        e.wrp = w;
        e.cyc = c;
        cnt_q.push_back(e);
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    // Count monitor: every change of count_bcd is one transaction.
    initial begin
        logic [15:0] last_cnt;
        bit          chg_prev;
        cnt_exp_t    e;
        last_cnt = 16'h0000;
        chg_prev = 1'b0;
        forever begin
            @(negedge clk);
            if (count_bcd !== last_cnt) begin
                if (mon_en) begin
                    if (cnt_q.size() == 0) begin
                        check("cnt_unexpected", count_bcd, last_cnt);
                    end else begin
                        e = cnt_q.pop_front();
                        check("cnt_value", count_bcd, e.cnt);
                        check("cnt_wrap", wrap, e.wrp);
                        check("cnt_cycle", cyc, e.cyc);
                        $display("[TB] cyc %0d count %h wrap %0b", cyc, count_bcd, wrap);
                    end
                end
                chg_prev = 1'b1;
            end else begin
                if (mon_en && chg_prev) check("wrap_width", wrap, 1'b0);
                chg_prev = 1'b0;
            end
            last_cnt = count_bcd;
        end
    end

    // Scan monitor: every anode change is one transaction while expectations exist.
    initial begin
        logic [3:0] last_an;
        int         last_cyc;
        scan_exp_t  s;
        last_an  = 4'hF;
        last_cyc = 0;
        forever begin
            @(negedge clk);
            if (an !== last_an) begin
                if (scan_q.size() > 0) begin
                    s = scan_q.pop_front();
                    check("scan_an", an, s.an);
                    check("scan_an_nb", an_nb, s.an);
                    check("scan_seg", seg, s.seg);
                    check("scan_seg_nb", seg_nb, s.seg_nb);
                    check("scan_gap", cyc - last_cyc, 2);
                    $display("[TB] cyc %0d an %b seg %b seg_nb %b", cyc, an, seg, seg_nb);
                end
                last_an  = an;
                last_cyc = cyc;
            end
        end
    end

    initial begin
        int        c;
        int        k;
        bit        found;
        scan_exp_t s;
        logic [3:0] an_tab [4];
        logic [6:0] seg_tab [4];
        logic [6:0] nb_tab [4];
        an_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
        seg_tab = '{7'b0000001, 7'b0001111, 7'b1111111, 7'b1111111};
        nb_tab  = '{7'b0000001, 7'b0001111, 7'b0000001, 7'b0000001};

        en = 1'b0; up = 1'b1; clear = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_async_count", count_bcd, 16'h0000);
        check("rst_async_an", an, 4'b1111);
        check("rst_async_seg", seg, 7'b1111111);
        repeat (3) @(negedge clk);
        check("rst_hold_count", count_bcd, 16'h0000);
        check("rst_hold_wrap", wrap, 1'b0);
        check("rst_hold_an", an, 4'b1111);
        check("rst_hold_seg_nb", seg_nb, 7'b1111111);

        // Count up from reset: ten ticks, 0001..0010.
        c = cyc;
        rst = 1'b0; en = 1'b1; up = 1'b1;
        for (int i = 1; i <= 10; i++) push_cnt(bcd(i), 1'b0, c + 4 * i);
        wait_cyc(c + 1);
        check("first_scan_idle_an", an, 4'b1111);
        wait_cyc(c + 2);
        check("first_scan_an", an, 4'b1110);
        check("first_scan_seg", seg, 7'b0000001);

        // Count down through zero into 9999, then up back into 0000.
        wait_cyc(c + 40);
        c = cyc;
        up = 1'b0;
        for (int i = 1; i <= 10; i++) push_cnt(bcd(10 - i), 1'b0, c + 4 * i);
        push_cnt(16'h9999, 1'b1, c + 44);
        wait_cyc(c + 44);
        up = 1'b1;
        c = cyc;
        push_cnt(16'h0000, 1'b1, c + 4);
        c = c + 4;

        // Up to 0042, freeze with prescaler at 2 for ten cycles.
        for (int i = 1; i <= 42; i++) push_cnt(bcd(i), 1'b0, c + 4 * i);
        push_cnt(bcd(43), 1'b0, c + 182);
        wait_cyc(c + 170);
        en = 1'b0;
        wait_cyc(c + 180);
        en = 1'b1;
        c = c + 182;

        // Up to 0123, then clear coincident with the next tick.
        for (int i = 1; i <= 80; i++) push_cnt(bcd(43 + i), 1'b0, c + 4 * i);
        push_cnt(16'h0000, 1'b0, c + 324);
        wait_cyc(c + 323);
        clear = 1'b1;
        wait_cyc(c + 324);
        clear = 1'b0;
        c = c + 324;
        push_cnt(bcd(1), 1'b0, c + 4);
        c = c + 4;

        // Up to 0070 and freeze for the display scan.
        for (int i = 1; i <= 69; i++) push_cnt(bcd(1 + i), 1'b0, c + 4 * i);
        wait_cyc(c + 276);
        en = 1'b0;

        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (an == 4'b0111) begin
                found = 1'b1;
                break;
            end
        end
        check("scan_sync", found, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            s.an     = an_tab[i % 4];
            s.seg    = seg_tab[i % 4];
            s.seg_nb = nb_tab[i % 4];
            scan_q.push_back(s);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (scan_q.size() == 0) break;
        end

        // Clear while disabled, then one tick from a cleared prescaler.
        k = cyc;
        clear = 1'b1;
        push_cnt(16'h0000, 1'b0, k + 1);
        wait_cyc(k + 1);
        clear = 1'b0;
        en = 1'b1;
        push_cnt(bcd(1), 1'b0, k + 5);
        wait_cyc(k + 6);
        check("cnt_drain", cnt_q.size(), 0);
        check("scan_drain", scan_q.size(), 0);

        // Asynchronous reset between clock edges, mid-scan and mid-count.
        mon_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("rst_mid_count", count_bcd, 16'h0000);
        check("rst_mid_wrap", wrap, 1'b0);
        check("rst_mid_an", an, 4'b1111);
        check("rst_mid_seg", seg, 7'b1111111);
        #20 rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
